// File: rtl/sq_pkg.sv
// rtl/sq_pkg.sv - shared types and constants for the stack/queue calculator
//
// Contents:
//   SQ_DEPTH, SQ_WIDTH  default buffer depth and data word width
//   sq_state_e          sequencer states IDLE, POP1, POP2, EXEC, WB
//   OP_ADD..OP_DIV      one-hot ALU operation codes; btns[1] maps to OP_ADD,
//                       btns[2] to OP_SUB, btns[3] to OP_MUL, btns[4] to OP_DIV
//   op_select           picks the lowest requested operation bit

package sq_pkg;

    localparam int SQ_DEPTH = 8;
    localparam int SQ_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        POP1,
        POP2,
        EXEC,
        WB
    } sq_state_e;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b1000;

    // Several operation buttons can rise in the same cycle; the lowest
    // index has priority so the result is always a single one-hot code.
    function automatic logic [3:0] op_select(input logic [3:0] req);
        logic [3:0] sel;
        sel = 4'b0000;
        if (req[0]) begin
            sel = OP_ADD;
        end else if (req[1]) begin
            sel = OP_SUB;
        end else if (req[2]) begin
            sel = OP_MUL;
        end else if (req[3]) begin
            sel = OP_DIV;
        end
        return sel;
    endfunction

endpackage

// File: rtl/sq_buffer.sv
// rtl/sq_buffer.sv - circular operand buffer with stack and queue pop ports
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   push         write push_data at tail, then advance tail
//   push_data    word to store
//   pop_lifo     drop the entry at tail-1 (tail decrements)
//   pop_fifo     drop the entry at head (head increments)
//   top_data     entry at tail-1 (newest)
//   head_data    entry at head (oldest)
//   count        number of valid entries, 0..DEPTH
//   empty, full  status decoded from count
//
// The owner never pops an empty buffer or pushes a full one, and never
// asserts more than one strobe per cycle.

module sq_buffer
    import sq_pkg::*;
#(
    parameter int DEPTH = SQ_DEPTH,
    parameter int WIDTH = SQ_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop_lifo,
    input  logic                   pop_fifo,
    output logic [WIDTH-1:0]       top_data,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] top_idx;
    logic [CNT_W-1:0] count_q, count_d;

    // DEPTH is a power of two, so plain pointer arithmetic wraps modulo DEPTH.
    assign top_idx = tail_q - PTR_W'(1);

    always_comb begin
        head_d  = head_q + PTR_W'(pop_fifo);
        tail_d  = tail_q + PTR_W'(push) - PTR_W'(pop_lifo);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop_lifo) - CNT_W'(pop_fifo);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset: a zero count already marks every entry invalid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= push_data;
        end
    end

    assign top_data  = mem_q[top_idx];
    assign head_data = mem_q[head_q];
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/stack_queue_ctrl.sv
// rtl/stack_queue_ctrl.sv - operand store and sequencer for the stack/queue calculator
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   stack_queue     1 = stack (LIFO) order, 0 = queue (FIFO) order
//   switches        operand value, zero-extended to WIDTH on push
//   btns            debounced buttons: [0] push, [4:1] add/sub/mul/div
//   alu_y           result from the external combinational ALU
//   alu_a, alu_b    registered ALU operands
//   alu_op          registered one-hot ALU operation
//   sseg            display value: top (stack) or head (queue), 0 when empty
//   empty, full     buffer status
//   err             one-cycle pulse after a rejected request

module stack_queue_ctrl
    import sq_pkg::*;
#(
    parameter int DEPTH = SQ_DEPTH,
    parameter int WIDTH = SQ_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stack_queue,
    input  logic [15:0]      switches,
    input  logic [4:0]       btns,
    input  logic [WIDTH-1:0] alu_y,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] sseg,
    output logic             empty,
    output logic             full,
    output logic             err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    sq_state_e        state_q, state_d;
    logic [4:0]       btns_q, btns_d;
    logic [4:0]       btn_rise;
    logic             push_edge;
    logic [3:0]       op_edge;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             err_q, err_d;
    logic             push_pend_q, push_pend_d;
    logic [WIDTH-1:0] push_val_q, push_val_d;

    logic             buf_push;
    logic [WIDTH-1:0] buf_wdata;
    logic             pop_lifo, pop_fifo;
    logic [WIDTH-1:0] top_data, head_data;
    logic [CNT_W-1:0] count;
    logic             buf_empty, buf_full;
    logic [CNT_W:0]   avail;
    logic             disp_stack;

    // Rising edge: the button is high now and was low last cycle.
    assign btns_d    = btns;
    assign btn_rise  = btns & ~btns_q;
    assign push_edge = btn_rise[0];
    assign op_edge   = btn_rise[4:1];

    // An accepted push lands one cycle later, so an op decided in that
    // cycle must already count the pending entry as available.
    assign avail = {1'b0, count} + (CNT_W+1)'(push_pend_q);

    // The pending push is only ever set from IDLE and drains in the next
    // (still IDLE) cycle, so it never collides with the WB write.
    assign buf_push  = push_pend_q | (state_q == WB);
    assign buf_wdata = (state_q == WB) ? res_q : push_val_q;

    sq_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (buf_push),
        .push_data (buf_wdata),
        .pop_lifo  (pop_lifo),
        .pop_fifo  (pop_fifo),
        .top_data  (top_data),
        .head_data (head_data),
        .count     (count),
        .empty     (buf_empty),
        .full      (buf_full)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        res_d       = res_q;
        err_d       = 1'b0;
        push_pend_d = 1'b0;
        push_val_d  = push_val_q;
        pop_lifo    = 1'b0;
        pop_fifo    = 1'b0;

        case (state_q)
            IDLE: begin
                // An operation request takes precedence over a push edge
                // arriving in the same cycle; the push is simply dropped.
                if (|op_edge) begin
                    if (avail >= (CNT_W+1)'(2)) begin
                        mode_d   = stack_queue;
                        alu_op_d = op_select(op_edge);
                        state_d  = POP1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (push_edge) begin
                    if (buf_full) begin
                        err_d = 1'b1;
                    end else begin
                        push_pend_d = 1'b1;
                        push_val_d  = WIDTH'(switches);
                    end
                end
            end
            POP1: begin
                // Stack order yields the right operand first, queue order
                // the left one, so a-op-b keeps entry order in both modes.
                if (mode_q) begin
                    pop_lifo = 1'b1;
                    alu_b_d  = top_data;
                end else begin
                    pop_fifo = 1'b1;
                    alu_a_d  = head_data;
                end
                state_d = POP2;
            end
            POP2: begin
                if (mode_q) begin
                    pop_lifo = 1'b1;
                    alu_a_d  = top_data;
                end else begin
                    pop_fifo = 1'b1;
                    alu_b_d  = head_data;
                end
                state_d = EXEC;
            end
            EXEC: begin
                res_d   = alu_y;
                state_d = WB;
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            btns_q      <= '0;
            mode_q      <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            res_q       <= '0;
            err_q       <= 1'b0;
            push_pend_q <= 1'b0;
            push_val_q  <= '0;
        end else begin
            state_q     <= state_d;
            btns_q      <= btns_d;
            mode_q      <= mode_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            res_q       <= res_d;
            err_q       <= err_d;
            push_pend_q <= push_pend_d;
            push_val_q  <= push_val_d;
        end
    end

    // While idle the display follows the live mode switch; during an
    // operation it uses the mode that operation was started with.
    assign disp_stack = (state_q == IDLE) ? stack_queue : mode_q;

    always_comb begin
        sseg = '0;
        if (!buf_empty) begin
            sseg = disp_stack ? top_data : head_data;
        end
    end

    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;
    assign err    = err_q;
    assign empty  = buf_empty;
    assign full   = buf_full;

endmodule

// File: tb/tb_stack_queue_ctrl.sv
// tb/tb_stack_queue_ctrl.sv - self-checking bench for stack_queue_ctrl

module tb_stack_queue_ctrl;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst = 1'b1;
    logic        stack_queue;
    logic [15:0] switches;
    logic [4:0]  btns;
    logic [31:0] alu_y;
    logic [31:0] alu_a, alu_b, sseg;
    logic [3:0]  alu_op;
    logic        empty, full, err;

    int total = 0;
    int bad   = 0;

    stack_queue_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .stack_queue (stack_queue),
        .switches    (switches),
        .btns        (btns),
        .alu_y       (alu_y),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .sseg        (sseg),
        .empty       (empty),
        .full        (full),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] bench_alu(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op);
        case (op)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd4:    return a * b;
            4'd8:    return (b == 0) ? 32'd0 : a / b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_y = bench_alu(alu_a, alu_b, alu_op);

    function automatic logic [3:0] lowest_bit(input logic [3:0] req);
        for (int i = 0; i < 4; i++) begin
            if (req[i]) return 4'(1 << i);
        end
        return 4'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: buffer contents as a deque, oldest first. An accepted op
    // occupies four cycles: two pops, ALU evaluation, result append.
    logic [31:0] dq[$];
    logic [4:0]  m_prev;
    int          m_busy;
    logic        m_mode, m_err, m_pend;
    logic [31:0] m_a, m_b, m_res, m_pval;
    logic [3:0]  m_op;

    always @(posedge clk or posedge rst) begin
        logic [4:0] e;
        int         avail;
        if (rst) begin
            dq.delete();
            m_prev = '0; m_busy = 0; m_mode = 0; m_err = 0; m_pend = 0;
            m_a = 0; m_b = 0; m_res = 0; m_pval = 0; m_op = 0;
        end else begin
            e      = btns & ~m_prev;
            m_prev = btns;
            avail  = dq.size() + (m_pend ? 1 : 0);
            m_err  = 0;
            if (m_pend) begin
                dq.push_back(m_pval);
                m_pend = 0;
            end
            if (m_busy == 0) begin
                if (e[4:1] != 0) begin
                    if (avail >= 2) begin
                        m_op   = lowest_bit(e[4:1]);
                        m_mode = stack_queue;
                        m_busy = 4;
                    end else begin
                        m_err = 1;
                    end
                end else if (e[0]) begin
                    if (avail == DEPTH) begin
                        m_err = 1;
                    end else begin
                        m_pend = 1;
                        m_pval = {16'd0, switches};
                    end
                end
            end else begin
                case (m_busy)
                    4: if (m_mode) m_b = dq.pop_back(); else m_a = dq.pop_front();
                    3: if (m_mode) m_a = dq.pop_back(); else m_b = dq.pop_front();
                    2: m_res = bench_alu(m_a, m_b, m_op);
                    default: dq.push_back(m_res);
                endcase
                m_busy--;
            end
        end
    end

    always @(negedge clk) begin
        logic        disp_stack;
        logic [31:0] exp_sseg;
        disp_stack = (m_busy == 0) ? stack_queue : m_mode;
        exp_sseg   = 32'd0;
        if (dq.size() != 0) begin
            if (disp_stack) exp_sseg = dq[dq.size()-1];
            else            exp_sseg = dq[0];
        end
        chk("sseg",   sseg,   exp_sseg);
        chk("empty",  empty,  32'(dq.size() == 0));
        chk("full",   full,   32'(dq.size() == DEPTH));
        chk("err",    err,    32'(m_err));
        chk("alu_a",  alu_a,  m_a);
        chk("alu_b",  alu_b,  m_b);
        chk("alu_op", alu_op, 32'(m_op));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(input logic [4:0] b);
        btns = b;
        cyc(1);
        btns = '0;
        cyc(1);
    endtask

    task automatic push_val(input logic [15:0] v);
        switches = v;
        press(5'b00001);
        cyc(1);
    endtask

    task automatic do_op(input logic [4:0] b);
        press(b);
        cyc(6);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
    endtask

    initial begin
        btns        = '0;
        switches    = '0;
        stack_queue = 1'b1;
        cyc(2);
        chk("rst_sseg",  sseg,   0);
        chk("rst_empty", empty,  1);
        chk("rst_full",  full,   0);
        chk("rst_err",   err,    0);
        chk("rst_alu_a", alu_a,  0);
        chk("rst_alu_op", alu_op, 0);
        rst = 1'b0;
        cyc(1);

        // stack: 3 + 5
        push_val(16'd3);
        push_val(16'd5);
        do_op(5'b00010);
        chk("t1_alu_a", alu_a, 3);
        chk("t1_alu_b", alu_b, 5);
        chk("t1_sseg",  sseg,  8);
        chk("t1_op",    alu_op, 1);
        chk("t1_count", dq.size(), 1);

        // queue: 7 2 9, then 7 - 2
        do_reset();
        stack_queue = 1'b0;
        push_val(16'd7);
        push_val(16'd2);
        push_val(16'd9);
        chk("t2_head", sseg, 7);
        stack_queue = 1'b1;
        #1;
        chk("t2_top", sseg, 9);
        stack_queue = 1'b0;
        cyc(1);
        do_op(5'b00100);
        chk("t2_alu_a", alu_a, 7);
        chk("t2_alu_b", alu_b, 2);
        chk("t2_sseg",  sseg,  9);
        chk("t2_count", dq.size(), 2);

        // fill, overflow attempt, then pointer wrap in both pop orders
        do_reset();
        stack_queue = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_val(16'(10 + i));
        chk("t3_full", full, 1);
        switches = 16'd99;
        btns = 5'b00001;
        cyc(1);
        chk("t3_err_hi", err, 1);
        btns = '0;
        cyc(1);
        chk("t3_err_lo", err, 0);
        chk("t3_head", sseg, 10);
        chk("t3_count", dq.size(), 8);
        stack_queue = 1'b1;
        do_op(5'b00010);
        chk("t3_s_a", alu_a, 16);
        chk("t3_s_b", alu_b, 17);
        chk("t3_s_sseg", sseg, 33);
        stack_queue = 1'b0;
        for (int i = 0; i < 4; i++) do_op(5'b00010);
        chk("t3_q_a", alu_a, 33);
        chk("t3_q_b", alu_b, 21);
        chk("t3_q_sseg", sseg, 25);
        chk("t3_q_count", dq.size(), 3);

        // op with one entry, then a push edge during the busy window
        do_reset();
        stack_queue = 1'b1;
        push_val(16'd4);
        btns = 5'b00010;
        cyc(1);
        chk("t4_err_hi", err, 1);
        btns = '0;
        cyc(1);
        chk("t4_err_lo", err, 0);
        chk("t4_alu_op", alu_op, 0);
        push_val(16'd6);
        push_val(16'd8);
        btns = 5'b01000;
        cyc(1);
        btns = '0;
        cyc(1);
        switches = 16'd77;
        btns = 5'b00001;
        cyc(1);
        btns = '0;
        cyc(6);
        chk("t4_sseg", sseg, 48);
        chk("t4_count", dq.size(), 2);

        // simultaneous push+op, then several op bits together
        do_reset();
        push_val(16'd20);
        push_val(16'd30);
        do_op(5'b01001);
        chk("t5_sseg", sseg, 600);
        chk("t5_count", dq.size(), 1);
        push_val(16'd50);
        do_op(5'b11100);
        chk("t5_op", alu_op, 2);
        chk("t5_sseg2", sseg, 550);

        // reset during POP2
        do_reset();
        push_val(16'd1);
        push_val(16'd2);
        btns = 5'b00010;
        cyc(1);
        btns = '0;
        cyc(1);
        chk("t6_pop1_b", alu_b, 2);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_sseg",  sseg,  0);
        chk("t6_empty", empty, 1);
        chk("t6_full",  full,  0);
        chk("t6_alu_a", alu_a, 0);
        chk("t6_alu_b", alu_b, 0);
        chk("t6_op",    alu_op, 0);
        chk("t6_err",   err,   0);
        cyc(1);
        rst = 1'b0;
        cyc(1);
        push_val(16'd5);
        chk("t6_after", sseg, 5);
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stack_queue_ctrl.md
# stack_queue_ctrl

Operand store and sequencer for the stack/queue calculator. It sits between the debounced button/switch inputs and the combinational ALU and seven-segment driver. It pushes switch values into a circular buffer and, on an operation button, pops two operands and drives them to the ALU. It then writes the ALU result back and presents the current top (stack mode) or head (queue mode) value for display.

## Interface
- DEPTH, 8: buffer entries; must be a power of two, at least 4.
- WIDTH, 32: data word width.
- clk  in  1  system clock; every register uses the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- stack_queue  in  1  mode select: 1 = stack (LIFO), 0 = queue (FIFO).
- switches  in  16  operand entry value; zero-extended to WIDTH.
- btns  in  5  debounced levels: btns[0] = push; btns[4:1] = operation request.
- alu_y  in  WIDTH  result from the combinational ALU.
- alu_a, alu_b  out  WIDTH  registered ALU operands.
- alu_op  out  4  registered one-hot operation code sent to the ALU.
- sseg  out  WIDTH  value to display.
- empty, full  out  1  buffer status; combinational from count.
- err  out  1  one-cycle pulse on a rejected request.

## Operation
- Button edges:
  - Each btns bit is registered once. A request is a rising edge: the bit is now 1 and was 0 in the previous cycle.
  - Edges are acted on only in IDLE. Edges that arrive while busy are dropped.
- Buffer storage:
  - Circular array with head pointer, tail pointer and count (0..DEPTH).
  - Every push writes at tail, then tail increments.
  - Stack pop reads at tail-1, then tail decrements.
  - Queue pop reads at head, then head increments.
  - Pointers wrap modulo DEPTH.
- Mode:
  - stack_queue is sampled when a request is accepted in IDLE and held until the state returns to IDLE.
  - A mode change does not alter stored data; only pop order and display change.
- FSM states and transitions:
  - IDLE: a push edge with count < DEPTH writes {16'b0, switches}. A push edge with full set pulses err and writes nothing. An op edge with count >= 2 latches alu_op and goes to POP1. An op edge with count < 2 pulses err.
  - POP1: pop one entry. In stack mode it goes to alu_b; in queue mode it goes to alu_a. Go to POP2.
  - POP2: pop the second entry into the other operand register. Go to EXEC.
  - EXEC: alu_a, alu_b and alu_op are stable; wait one cycle for the ALU. Go to WB.
  - WB: push alu_y at tail. Go to IDLE.
- Simultaneous requests:
  - Push and op edges in the same cycle: the op wins; the push is dropped.
  - Several op bits rising together: the lowest index wins.
- Overflow: not possible. WB always has room, because two entries were popped before it.
- Display (sseg):
  - Stack mode: entry at tail-1. Queue mode: entry at head.
  - 0 when empty.
  - Combinational from the pointers and the array.

## Timing
- Reset values: pointers and count 0; alu_a, alu_b, alu_op 0; state IDLE; err 0; empty=1, full=0; sseg=0.
- Reset asserted mid-operation aborts immediately. All buffer contents are treated as discarded.
- Push: edge registered in cycle n; entry written at the end of n+1; sseg, empty and full reflect it in n+2.
- Op:
  - Edge detected in cycle n.
  - Operands are valid on alu_a/alu_b from n+3; alu_y is sampled in EXEC (n+3).
  - Result is stored at the end of cycle n+4 and is visible on sseg in n+5.
- Busy window: 4 cycles, POP1 through WB.
- err: high for exactly one cycle, the cycle after the rejected edge.

## Structure
- Shared package sq_pkg holds:
  - state enum: IDLE, POP1, POP2, EXEC, WB;
  - default DEPTH and WIDTH;
  - op one-hot constants OP_ADD, OP_SUB, OP_MUL, OP_DIV, mapped to btns[1..4].
- One natural sub-module, sq_buffer:
  - the array plus head/tail/count;
  - push, pop_lifo and pop_fifo strobes;
  - top/head read ports.
- The FSM and edge detection stay in stack_queue_ctrl.

## Test plan
- Reset, then push switches=3 then 5 in stack mode, then op btns[1] with alu_y forced to a+b → alu_a=3, alu_b=5, sseg=8, count=1.
- Queue mode: push 7, 2, 9, then op btns[2] → alu_a=7, alu_b=2; result written at tail; sseg then shows head=9.
- Push DEPTH+1 values → full=1 after DEPTH pushes; the extra push pulses err and leaves contents unchanged. Pops wrap the pointers correctly across index DEPTH-1 → 0.
- Op with count=1 → err pulses and state stays IDLE. A push edge during the POP1–WB window is ignored, and count after WB is the pre-op count minus 1.
- Push and btns[3] rise in the same cycle with count=2 → only the op executes. Assert rst in POP2 → all outputs return to their reset values and empty=1.
